// File: rtl/sram_controller_if.sv
// ---------------------------------------------------------------------------
// sram_controller_if
//   Pipeline-side handshake between the MEM stage and the SRAM controller.
//   The SRAM pins stay as plain ports on the controller. The SRAM data bus is
//   bidirectional, so it is kept where the tristate is resolved.
//
//   wr_en      : store request (MEM stage -> controller)
//   rd_en      : load request  (MEM stage -> controller)
//   address    : byte address of the access
//   write_data : store data
//   read_data  : registered load result (controller -> MEM stage)
//   ready      : 1 = no access pending or access completing; 0 = stall
// ---------------------------------------------------------------------------
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en,
    output rd_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );
endinterface

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//   Turns single-cycle MEM-stage load/store requests into multi-cycle accesses
//   on an external 32-bit asynchronous SRAM. While an access is in flight,
//   ready is held low to freeze the pipeline.
//
//   Ports
//     clk        : system clock; all state changes on the rising edge
//     rst        : synchronous, active-high reset
//     mem_if     : pipeline handshake (slave side); see sram_controller_if
//     sram_addr  : SRAM word address (registered)
//     sram_dq    : SRAM data bus, driven only while sram_we_n is low
//     sram_we_n  : SRAM write enable, active low (registered)
//
//   State  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no access; ready follows "no request present"
//   ACCESS | SRAM bus held for ACCESS_CYCLES cycles; cnt counts them
//   DONE   | access completes; ready=1 for one cycle, then back to IDLE
//
//   Timing: if a request is first seen in cycle 0, ready=1 in cycle
//   ACCESS_CYCLES+1.
// ---------------------------------------------------------------------------
module sram_controller #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int          ACCESS_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   mem_if,
  output logic [16:0]        sram_addr,
  inout  wire  [31:0]        sram_dq,
  output logic               sram_we_n
);

  if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > 15)) begin : g_bad_cycles
    $error("sram_controller: ACCESS_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        op_wr_q;
  logic [31:0] wdata_q;
  logic [31:0] read_data_q;
  logic [16:0] sram_addr_q;
  logic        we_n_q;

  logic        req;
  logic [31:0] offset;
  logic [16:0] word_addr;
  logic        unused_offset_bits;

  assign req = mem_if.wr_en | mem_if.rd_en;

  // Byte address relative to the data segment, converted to a word index.
  // Addresses below BASE_ADDR wrap modulo 2^17 on purpose.
  assign offset             = mem_if.address - BASE_ADDR;
  assign word_addr          = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      op_wr_q     <= 1'b0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
      sram_addr_q <= 17'd0;
      we_n_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            // When both enables are set, the store takes priority.
            op_wr_q     <= mem_if.wr_en;
            wdata_q     <= mem_if.write_data;
            sram_addr_q <= word_addr;
            cnt_q       <= 4'd0;
            // Write enable is decoded from the next state and registered,
            // so it is low for exactly the ACCESS cycles.
            we_n_q      <= ~mem_if.wr_en;
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            if (!op_wr_q) begin
              read_data_q <= sram_dq;
            end
            we_n_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Return to IDLE without checking the request, so a request that
          // is still asserted is not issued a second time.
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          we_n_q  <= 1'b1;
        end
      endcase
    end
  end

  // ready falls in the same cycle a request arrives, so the pipeline freezes
  // before it advances past the load/store.
  assign mem_if.ready     = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
  assign mem_if.read_data = read_data_q;

  assign sram_addr = sram_addr_q;
  assign sram_we_n = we_n_q;

  // The same register gates the data driver and the write enable, so the bus
  // is never driven while the SRAM may be driving it.
  assign sram_dq = we_n_q ? 32'bz : wdata_q;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Multi-cycle controller between the MEM stage and the external 32-bit SRAM model (17-bit word address, shared bidirectional data bus, active-low write enable).
- Turns single-cycle pipeline load/store requests into timed SRAM accesses.
- Holds `ready` low to freeze the pipeline until the access completes.
- Translates the byte address of the data segment into an SRAM word address.

Parameters:
- BASE_ADDR, 32'd1024, byte address that maps to SRAM word 0.
- ACCESS_CYCLES, 5, cycles the SRAM bus is held per access; legal range 1..15; covers the SRAM's 30 ns read delay.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  store request from MEM stage
- rd_en  input  1  load request from MEM stage
- address  input  32  byte address of the access
- write_data  input  32  store data
- read_data  output  32  load result, registered
- ready  output  1  1 = no access pending or access completing this cycle; 0 = stall pipeline
- sram_addr  output  17  SRAM word address
- sram_dq  inout  32  SRAM data bus
- sram_we_n  output  1  SRAM write enable, active low

Behaviour:
- States: IDLE, ACCESS, DONE, held in a state register plus a 4-bit counter `cnt`.
- Reset (rst=1 at a clk edge, any state, including mid-ACCESS):
  - state=IDLE, cnt=0, read_data=0, sram_addr=0, sram_we_n=1, sram_dq=Z.
  - An aborted write performs no further SRAM write edges.
- IDLE, no request: ready=1, sram_we_n=1, sram_dq=Z.
- IDLE, rd_en or wr_en=1:
  - ready=0 combinationally in the same cycle.
  - Latch op (write if wr_en=1; wr_en wins if both are asserted), the address and write_data.
  - sram_addr <= (address - BASE_ADDR) >> 2, truncated to 17 bits. Addresses below BASE_ADDR wrap modulo 2^17; no error is flagged.
  - Next state ACCESS, cnt=0.
- ACCESS:
  - ready=0.
  - Write: sram_we_n=0 and sram_dq driven with the latched data for all ACCESS cycles. Repeated writes of the same word are acceptable.
  - Read: sram_we_n=1 and sram_dq=Z.
  - Each cycle cnt increments.
  - When cnt==ACCESS_CYCLES-1: for a read, read_data <= sram_dq; next state DONE.
- DONE:
  - ready=1, sram_we_n=1, sram_dq=Z.
  - sram_addr holds its value.
  - Next state IDLE unconditionally, so the still-asserted request is not re-issued.
- Latency: for a request first seen in cycle 0, ready=1 in cycle ACCESS_CYCLES+1 (default: cycle 6). read_data is valid from that cycle on.
- read_data holds the last completed load until the next load completes; stores do not change it.
- Input changes during ACCESS or DONE (rd_en/wr_en dropped, address changed) are ignored; the latched operation completes.
- Back-to-back requests: a request present in the IDLE cycle after DONE starts immediately, giving one request every ACCESS_CYCLES+2 cycles.
- Bus hygiene:
  - The controller never drives sram_dq while sram_we_n=1.
  - sram_we_n is registered (glitch-free), from a registered next-state decode.

Test Plan:
- Store then load: wr_en, address=1024, write_data=32'hDEADBEEF → ready=0 for cycles 0-5, ready=1 in cycle 6, sram_addr=0 during the access. Then rd_en, address=1024 → read_data=32'hDEADBEEF with ready=1 at cycle 6 of that request.
- Address mapping: store 32'h12345678 at address 1024+4*37 → sram_addr=37; a load from the same address returns 32'h12345678, and a load from word 36 returns its own prior value, not the new data.
- Both enables: wr_en=1 and rd_en=1 with write_data=32'h0000_00AA → write performed (sram_we_n=0 during ACCESS), read_data unchanged.
- Request dropped mid-access: rd_en pulsed for one cycle only → access still completes, ready=1 at cycle 6 with read_data loaded, then IDLE with ready=1.
- Reset mid-write: rst=1 in the third ACCESS cycle → next cycle state IDLE, sram_we_n=1, sram_dq=Z, read_data=0, ready=1. A subsequent load returns either the old or the new data with no bus contention (X on sram_dq is a failure).
- Back-to-back loads of words 0 and 1 (prepopulated 32'h11, 32'h22): ready pulses high exactly at cycles 6 and 13, and read_data equals 32'h11 and then 32'h22 at those cycles.
